// File: rtl/mem_dump_tx.sv
// Walks a 16 x 8 synchronous RAM from address 0 to 15 and sends each byte
// as an 8N1 serial frame on tx, absorbing the RAM's one-cycle read latency.
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] ra,
  input  logic [7:0] dout,
  output logic       busy,
  output logic       tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      ra_q, ra_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    baud_d   = '0;
    bit_done = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        shift_d = dout;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        // The address check precedes the increment, so ra never wraps mid-dump.
        if (bit_done) begin
          if (ra_q == 4'd15) begin
            state_d = S_IDLE;
          end else begin
            ra_d    = ra_q + 4'd1;
            state_d = S_FETCH;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // tx is registered, so it is computed from the state being entered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    ra   = ra_q;
    tx   = tx_q;
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Scoreboard bench for mem_dump_tx: a behavioural RAM feeds the DUT, a UART
// monitor decodes tx and compares each byte against the expected queue.
module tb_mem_dump_tx;

  localparam int CPB         = 4;
  localparam int FRAME_LEN   = 10 * CPB;
  localparam int BYTE_PERIOD = FRAME_LEN + 2;
  localparam int DUMP_CYCLES = 16 * BYTE_PERIOD;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ra;
  logic [7:0] dout;
  logic       busy;
  logic       tx;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t0 = 0;
  bit         noise_en = 1'b0;
  bit         abort_frame = 1'b0;

  mem_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ra    (ra),
    .dout  (dout),
    .busy  (busy),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM; with noise on, dout is garbage except in the LATCH cycle.
  always @(posedge clk) begin
    if (noise_en && ((cyc - t0) % BYTE_PERIOD) != 1)
      dout <= 8'($urandom);
    else
      dout <= mem[ra];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic hold);
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  function automatic logic [FRAME_LEN-1:0] frame_wave(input logic [7:0] b);
    logic [9:0] bits;
    logic [FRAME_LEN-1:0] w;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME_LEN; i++) w[i] = bits[i / CPB];
    return w;
  endfunction

  task automatic push_dump();
    for (int i = 0; i < 16; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
  endtask

  task automatic wait_dump(input int base, output int busy_len, output int end_rel,
                           output int first_fall, output logic [3:0] ra_first,
                           output logic [FRAME_LEN-1:0] wave);
    int rel;
    busy_len   = 0;
    end_rel    = -1;
    first_fall = -1;
    ra_first   = 4'hx;
    wave       = '0;
    for (int k = 0; k < DUMP_CYCLES + 200; k++) begin
      rel = cyc - base;
      if (rel == 1) ra_first = ra;
      if (rel >= 3 && rel < 3 + FRAME_LEN) wave[rel-3] = tx;
      if (first_fall < 0 && tx === 1'b0) first_fall = rel;
      if (busy === 1'b1) begin
        busy_len++;
      end else if (busy_len > 0) begin
        end_rel = rel;
        break;
      end
      @(negedge clk);
    end
    if (end_rel < 0) checkOutput("dump_timeout", 64'(busy_len), 64'(DUMP_CYCLES));
  endtask

  // UART receiver: samples mid-bit, compares each decoded byte with the queue.
  initial begin
    logic [7:0] b;
    logic start_ok, stop_ok;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        start_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_ok = (tx === 1'b1);
        if (!abort_frame) begin
          checkOutput("frame_pending", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) checkOutput("rx_byte", 64'(b), 64'(exp_q.pop_front()));
          checkOutput("framing", 64'({start_ok, stop_ok}), 64'(2'b11));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_len, end_rel, first_fall, bad;
    logic [3:0] ra_first;
    logic [FRAME_LEN-1:0] wave;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_tx", 64'(tx), 64'(1));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_ra", 64'(ra), 64'(0));
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || ra !== 4'd0) bad++;
    end
    checkOutput("idle_hold_bad_cycles", 64'(bad), 64'(0));

    $display("[TB] single dump");
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
    push_dump();
    noise_en = 1'b1;
    applyStimulus(1'b0);
    wait_dump(t0, busy_len, end_rel, first_fall, ra_first, wave);
    checkOutput("single_busy_len", 64'(busy_len), 64'(672));
    checkOutput("single_busy_end", 64'(end_rel), 64'(673));
    checkOutput("single_first_fall", 64'(first_fall), 64'(3));
    checkOutput("single_ra_first", 64'(ra_first), 64'(0));
    checkOutput("single_wave0", 64'(wave), 64'(frame_wave(8'hA0)));
    checkOutput("single_all_rx", 64'(exp_q.size()), 64'(0));
    noise_en = 1'b0;

    $display("[TB] bit order");
    randomize_mem();
    mem[0] = 8'h01;
    push_dump();
    applyStimulus(1'b0);
    wait_dump(t0, busy_len, end_rel, first_fall, ra_first, wave);
    checkOutput("bitorder_wave", 64'(wave), 64'(40'hF0000000F0));
    checkOutput("bitorder_busy_len", 64'(busy_len), 64'(672));
    checkOutput("bitorder_all_rx", 64'(exp_q.size()), 64'(0));

    $display("[TB] start while busy");
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
    push_dump();
    noise_en = 1'b1;
    applyStimulus(1'b0);
    fork
      wait_dump(t0, busy_len, end_rel, first_fall, ra_first, wave);
      begin
        repeat (99) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    checkOutput("busystart_busy_len", 64'(busy_len), 64'(672));
    checkOutput("busystart_busy_end", 64'(end_rel), 64'(673));
    checkOutput("busystart_first_fall", 64'(first_fall), 64'(3));
    checkOutput("busystart_wave0", 64'(wave), 64'(frame_wave(8'hA0)));
    checkOutput("busystart_all_rx", 64'(exp_q.size()), 64'(0));
    noise_en = 1'b0;

    $display("[TB] held start");
    randomize_mem();
    push_dump();
    push_dump();
    applyStimulus(1'b1);
    wait_dump(t0, busy_len, end_rel, first_fall, ra_first, wave);
    checkOutput("held_first_busy_len", 64'(busy_len), 64'(672));
    checkOutput("held_first_end", 64'(end_rel), 64'(673));
    @(negedge clk);
    checkOutput("held_restart_busy", 64'(busy), 64'(1));
    checkOutput("held_restart_ra", 64'(ra), 64'(0));
    start = 1'b0;
    wait_dump(t0 + DUMP_CYCLES + 1, busy_len, end_rel, first_fall, ra_first, wave);
    checkOutput("held_second_busy_len", 64'(busy_len), 64'(672));
    checkOutput("held_second_wave0", 64'(wave), 64'(frame_wave(mem[0])));
    checkOutput("held_all_rx", 64'(exp_q.size()), 64'(0));

    $display("[TB] reset mid-frame");
    randomize_mem();
    mem[5] = mem[5] & 8'hFE;
    push_dump();
    applyStimulus(1'b0);
    repeat (5 * BYTE_PERIOD + 7) @(negedge clk);
    checkOutput("midframe_tx_low", 64'(tx), 64'(0));
    abort_frame = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midframe_reset_tx", 64'(tx), 64'(1));
    checkOutput("midframe_reset_busy", 64'(busy), 64'(0));
    repeat (60) @(negedge clk);
    checkOutput("midframe_still_idle", 64'({busy, tx}), 64'(2'b01));
    exp_q.delete();
    abort_frame = 1'b0;
    randomize_mem();
    push_dump();
    applyStimulus(1'b0);
    wait_dump(t0, busy_len, end_rel, first_fall, ra_first, wave);
    checkOutput("after_reset_ra_first", 64'(ra_first), 64'(0));
    checkOutput("after_reset_busy_len", 64'(busy_len), 64'(672));
    checkOutput("after_reset_wave0", 64'(wave), 64'(frame_wave(mem[0])));
    checkOutput("after_reset_all_rx", 64'(exp_q.size()), 64'(0));

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump_tx.md
# mem_dump_tx

Read-side companion to the 16 x 8 synchronous RAM in the lab 1 display design. On a start pulse, the block walks addresses 0 through 15. It absorbs the RAM's one-cycle read latency and transmits each byte as an 8N1 asynchronous serial frame on a single TX line, so the whole memory image can be captured by a host UART. Outside this block, a mux gives the RAM address and write enable to this block while `busy` is high and to the key controller otherwise.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 baud): clock cycles per serial bit. Legal range is 2 or more.
- `clk` input, 1 bit: the single clock. All state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: level sampled each cycle. Starts a dump only when the block is idle.
- `ra` output, 4 bits: RAM read address, registered.
- `dout` input, 8 bits: RAM read data. Valid one cycle after `ra` is presented.
- `busy` output, 1 bit: high from the cycle after `start` is accepted until the last stop bit ends. The external mux holds RAM `we` low while `busy` is high.
- `tx` output, 1 bit: serial line, registered. Idles high.

## Operation
- States:
  - IDLE: `tx`=1, `busy`=0. When `start`=1: `ra`<=0, go to FETCH.
  - FETCH: one cycle. The RAM samples `ra`. Go to LATCH.
  - LATCH: one cycle. Shift register <= `dout`, bit counter <= 0, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first. Each bit is held for `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then, if `ra`==15, go to IDLE. Otherwise `ra`<=`ra`+1 and go to FETCH.
- `busy` is 1 in every state except IDLE.
- `start` is ignored in every state except IDLE. A `start` held high after a dump completes begins a new dump on the first IDLE cycle.
- Baud counter:
  - Width is $clog2(`CLKS_PER_BIT`).
  - Counts 0 to `CLKS_PER_BIT`-1 and is cleared on every state entry.
  - A bit ends when the count reaches `CLKS_PER_BIT`-1.
- Bit counter is 3 bits. The address counter stays in 4 bits and never wraps within a dump, because the 15 check happens before the increment.
- The block never writes the RAM and never modifies `dout`. It has no internal copy of memory beyond the current byte.
- Reset values: `tx`=1, `busy`=0, `ra`=0, state IDLE, all counters 0.
- Reset takes priority over every transition, including mid-frame. `tx` is high on the cycle after `reset` is sampled, and no partial frame resumes.

## Timing
- Let cycle 0 be the cycle in which `start`=1 is sampled in IDLE:
  - Cycle 1: FETCH, `busy`=1, `ra`=0.
  - Cycle 2: LATCH.
  - Cycles 3 to 3+`CLKS_PER_BIT`-1: `tx`=0, the start bit.
- One frame is 10 x `CLKS_PER_BIT` cycles on `tx`. Between frames, `tx` stays high for exactly 2 extra cycles (FETCH and LATCH).
- One byte period is 10 x `CLKS_PER_BIT` + 2 cycles. A full dump keeps `busy` high for exactly 16 x (10 x `CLKS_PER_BIT` + 2) cycles.
- Changes on `dout` while outside LATCH have no effect on the byte in flight.

## Test plan
- **Reset:** with `CLKS_PER_BIT`=4, assert `reset` for 2 cycles. Required: `tx`=1, `busy`=0, `ra`=0; `start` held low keeps them unchanged for 100 cycles.
- **Single dump:** RAM preloaded with mem[i] = 8'hA0+i, `CLKS_PER_BIT`=4, one-cycle `start` pulse. Required: the bench UART decodes A0, A1, …, AF in order with no framing errors. `busy` is high for exactly 672 cycles. The first `tx` falling edge is 3 cycles after `start`.
- **Bit order:** mem[0]=8'h01. Required: `tx` shows 0 (start), 1, then seven 0s, then 1 (stop), each level held 4 cycles.
- **Start while busy:** pulse `start` again at cycle 100 of a dump. Required: the output is identical to the single-dump case and `busy` falls at 672.
- **Held start:** hold `start` high throughout. Required: the second dump's `busy` rises on the cycle after the first dump's IDLE cycle, and `ra` restarts at 0.
- **Reset mid-frame:** assert `reset` during a DATA bit of byte 5 while `tx`=0. Required: `tx`=1 and `busy`=0 on the next cycle. After reset is released, a new `start` begins again at address 0.
